// File: rtl/half_adder.sv
// Registered bank of WIDTH independent half adders with a valid qualifier and 1-cycle latency.
// Optional carry event counter enabled by defining HALF_ADDER_CARRY_CNT_EN.
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c,
    output logic [CNT_W-1:0] carry_cnt
);

    // Per-lane sum and carry. Lanes do not interact, so {c[i],s[i]} = a[i]+b[i].
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] carry_next;

    assign sum_next   = a ^ b;
    assign carry_next = a & b;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            c         <= '0;
        end else begin
            out_valid <= in_valid;
            // s/c are only loaded on valid cycles, so X on idle inputs never reaches them.
            if (in_valid) begin
                s <= sum_next;
                c <= carry_next;
            end
        end
    end

`ifdef HALF_ADDER_CARRY_CNT_EN
    logic any_carry;

    assign any_carry = in_valid && (|carry_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt <= '0;
        end else if (any_carry && (carry_cnt != {CNT_W{1'b1}})) begin
            // Saturating: holds at all-ones instead of wrapping.
            carry_cnt <= carry_cnt + CNT_W'(1);
        end
    end
`else
    assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: a WIDTH=1/CNT_W=2 instance and a WIDTH=8/CNT_W=16 instance.
// Counter expectations follow HALF_ADDER_CARRY_CNT_EN when it is defined for the build.
module tb_half_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
    logic       ov1, s1, c1;
    logic [1:0] cnt1;

    logic        v8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ov8;
    logic [7:0]  s8, c8;
    logic [15:0] cnt8;

    half_adder #(.WIDTH(1), .CNT_W(2)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
        .out_valid(ov1), .s(s1), .c(c1), .carry_cnt(cnt1)
    );

    half_adder #(.WIDTH(8), .CNT_W(16)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8),
        .out_valid(ov8), .s(s8), .c(c8), .carry_cnt(cnt8)
    );

    int total = 0;
    int bad   = 0;

    logic [1:0]  q1[$];   // {c,s}
    logic [15:0] q8[$];   // {c,s}
    int cnt_m1 = 0;
    int cnt_m8 = 0;

    // Reference: lane-by-lane integer addition, independent of the RTL's xor/and form.
    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] rs, rc;
        for (int i = 0; i < 8; i++) begin
            int sum;
            sum   = int'(x[i]) + int'(y[i]);
            rs[i] = (sum % 2) == 1;
            rc[i] = sum >= 2;
        end
        return {rc, rs};
    endfunction

    // Drivers run right after a falling edge; they push expectations, they do not compare.
    task automatic drive1(input logic v, input logic x, input logic y);
        int sum;
        v1 = v; a1 = x; b1 = y;
        if (v) begin
            sum = int'(x) + int'(y);
            q1.push_back(2'(sum));
`ifdef HALF_ADDER_CARRY_CNT_EN
            if (sum == 2 && cnt_m1 < 3) cnt_m1++;
`endif
        end
    endtask

    task automatic drive8(input logic v, input logic [7:0] x, input logic [7:0] y);
        v8 = v; a8 = x; b8 = y;
        if (v) begin
            q8.push_back(ref8(x, y));
`ifdef HALF_ADDER_CARRY_CNT_EN
            if ((x & y) != 8'h00 && cnt_m8 < 65535) cnt_m8++;
`endif
        end
    endtask

    task automatic clear_models();
        q1.delete();
        q8.delete();
        cnt_m1 = 0;
        cnt_m8 = 0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({ov1, s1, c1, cnt1} !== 5'b0) begin
            bad++;
            $display("FAIL reset_w1: got ov=%b s=%b c=%b cnt=%0d, want all 0", ov1, s1, c1, cnt1);
        end
        total++;
        if ({ov8, s8, c8, cnt8} !== 33'b0) begin
            bad++;
            $display("FAIL reset_w8: got ov=%b s=%h c=%h cnt=%0d, want all 0", ov8, s8, c8, cnt8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_models();
    endtask

    task automatic test_truth_table();
        logic [1:0] e;
        for (int i = 0; i < 4; i++) begin
            drive1(1'b1, 1'(i >> 1), 1'(i));
            @(negedge clk);
            total++;
            if (ov1 !== 1'b1) begin
                bad++;
                $display("FAIL tt_valid[%0d]: got %b want 1", i, ov1);
            end
            e = (q1.size() > 0) ? q1.pop_front() : 2'bxx;
            total++;
            if ({c1, s1} !== e) begin
                bad++;
                $display("FAIL tt_cs[%0d]: got c/s=%b/%b want %b/%b", i, c1, s1, e[1], e[0]);
            end
            total++;
            if (cnt1 !== 2'(cnt_m1)) begin
                bad++;
                $display("FAIL tt_cnt[%0d]: got %0d want %0d", i, cnt1, cnt_m1);
            end
        end
        drive1(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_width4();
        logic [15:0] e;
        drive8(1'b1, 8'b0000_1100, 8'b0000_1010);
        @(negedge clk);
        e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        total++;
        if (ov8 !== 1'b1 || {c8, s8} !== e) begin
            bad++;
            $display("FAIL w4_scoreboard: got ov=%b c=%b s=%b want ov=1 c=%b s=%b", ov8, c8, s8, e[15:8], e[7:0]);
        end
        total++;
        if (s8[3:0] !== 4'b0110 || c8[3:0] !== 4'b1000) begin
            bad++;
            $display("FAIL w4_lanes: got s=%b c=%b want s=0110 c=1000", s8[3:0], c8[3:0]);
        end
        drive8(1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_hold();
        logic [1:0]  e;
        logic [15:0] e8;
        drive1(1'b1, 1'b1, 1'b0);
        drive8(1'b1, 8'hA5, 8'h0F);
        @(negedge clk);
        e  = (q1.size() > 0) ? q1.pop_front() : 2'bxx;
        e8 = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        total++;
        if ({c1, s1} !== e) begin
            bad++;
            $display("FAIL hold_load: got c/s=%b/%b want %b/%b", c1, s1, e[1], e[0]);
        end
        for (int i = 0; i < 3; i++) begin
            drive1(1'b0, 1'b1, 1'b1);
            drive8(1'b0, 8'hxx, 8'hxx);
            @(negedge clk);
            total++;
            if (ov1 !== 1'b0 || s1 !== 1'b1 || c1 !== 1'b0) begin
                bad++;
                $display("FAIL hold_w1[%0d]: got ov=%b s=%b c=%b want ov=0 s=1 c=0", i, ov1, s1, c1);
            end
            total++;
            if (ov8 !== 1'b0 || {c8, s8} !== e8) begin
                bad++;
                $display("FAIL hold_x_w8[%0d]: got ov=%b c=%h s=%h want ov=0 c=%h s=%h", i, ov8, c8, s8, e8[15:8], e8[7:0]);
            end
        end
        drive8(1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset_mid();
        logic [1:0] e;
        drive1(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        if (q1.size() > 0) void'(q1.pop_front());
        #2 rst_n = 1'b0;
        clear_models();
        #1;
        total++;
        if ({ov1, s1, c1, cnt1} !== 5'b0) begin
            bad++;
            $display("FAIL reset_mid_async: got ov=%b s=%b c=%b cnt=%0d want all 0", ov1, s1, c1, cnt1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive1(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        total++;
        if (ov1 !== 1'b0 || s1 !== 1'b0 || c1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_idle: got ov=%b s=%b c=%b want 0 0 0", ov1, s1, c1);
        end
        drive1(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        e = (q1.size() > 0) ? q1.pop_front() : 2'bxx;
        total++;
        if (ov1 !== 1'b1 || {c1, s1} !== e) begin
            bad++;
            $display("FAIL reset_mid_first: got ov=%b c/s=%b/%b want ov=1 c/s=%b/%b", ov1, c1, s1, e[1], e[0]);
        end
        drive1(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_carry_cnt();
        @(negedge clk);
        rst_n = 1'b0;
        clear_models();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive1(1'b1, 1'b1, 1'b1);
            @(negedge clk);
            if (q1.size() > 0) void'(q1.pop_front());
            total++;
            if (cnt1 !== 2'(cnt_m1)) begin
                bad++;
                $display("FAIL carry_cnt[%0d]: got %0d want %0d", i, cnt1, cnt_m1);
            end
        end
        drive1(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        total++;
        if (cnt1 !== 2'(cnt_m1)) begin
            bad++;
            $display("FAIL carry_cnt_idle: got %0d want %0d", cnt1, cnt_m1);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        for (int i = 0; i < 1000; i++) begin
            drive8(1'b1, 8'($urandom), 8'($urandom));
            @(negedge clk);
            e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
            total++;
            if (ov8 !== 1'b1 || {c8, s8} !== e) begin
                bad++;
                $display("FAIL random[%0d]: got ov=%b c=%h s=%h want ov=1 c=%h s=%h", i, ov8, c8, s8, e[15:8], e[7:0]);
            end
            if (i % 100 == 99) begin
                total++;
                if (cnt8 !== 16'(cnt_m8)) begin
                    bad++;
                    $display("FAIL random_cnt[%0d]: got %0d want %0d", i, cnt8, cnt_m8);
                end
            end
        end
        drive8(1'b0, 8'h00, 8'h00);
        @(negedge clk);
        total++;
        if (ov8 !== 1'b0 || q8.size() != 0) begin
            bad++;
            $display("FAIL random_drain: got ov=%b pending=%0d want ov=0 pending=0", ov8, q8.size());
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_width4();
        test_hold();
        test_reset_mid();
        test_carry_cnt();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
